// File: rtl/orpsoc_debug_soc_if.sv
// JTAG pad bundle between the debug SoC shell and the JTAG bench model.
// The slave side is the SoC: it samples TMS/TCK/TDI and drives TDO.
interface orpsoc_debug_soc_if;
    logic tms_pad_i;
    logic tck_pad_i;
    logic tdi_pad_i;
    logic tdo_pad_o;

    modport slave (
        input  tms_pad_i,
        input  tck_pad_i,
        input  tdi_pad_i,
        output tdo_pad_o
    );

    modport master (
        output tms_pad_i,
        output tck_pad_i,
        output tdi_pad_i,
        input  tdo_pad_o
    );
endinterface

// File: rtl/orpsoc_debug_soc.sv
// Simulation SoC shell: a JTAG TAP whose 65-bit debug register reads and writes a
// word-addressed RAM, plus an optional console UART transmit register.

module orpsoc_debug_ram #(
    parameter int MEM_WORDS = 8192,
    parameter int AW        = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:MEM_WORDS-1];

    // Write port; contents are never reset so backdoor preloads survive
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

module orpsoc_debug_bfm_memory #(
    parameter int MEM_WORDS = 8192,
    parameter int AW        = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    orpsoc_debug_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) ram0 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule

module orpsoc_debug_soc #(
    parameter int          UART_SIM  = 0,
    parameter int          MEM_WORDS = 8192,
    parameter logic [31:0] IDCODE    = 32'h14951185,
    parameter logic [31:0] UART_BASE = 32'h90000000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    orpsoc_debug_soc_if.slave  jtag
);
    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] IR_IDCODE = 4'h2;
    localparam logic [3:0] IR_DEBUG  = 4'h8;

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_t;

    function automatic logic [AW-1:0] word_index(input logic [31:0] byte_addr);
        logic [29:0] word_s;
        word_s = byte_addr[31:2] % 30'(MEM_WORDS);
        return word_s[AW-1:0];
    endfunction

    logic        wb_rst;
    logic [2:0]  tck_pipe_r, tms_pipe_r, tdi_pipe_r;
    logic        tck_rise_s, tck_fall_s, tms_s, tdi_s;
    tap_state_t  tap_state_r, tap_next_s;
    logic [3:0]  ir_r, ir_sr_r;
    logic [31:0] idcode_sr_r;
    logic        bypass_sr_r;
    logic [64:0] debug_sr_r;
    logic        dr_lsb_s;
    logic        tdo_r;
    logic        wr_req_r, rd_req_r;
    logic [31:0] acc_addr_r, acc_data_r, rdata_r, ram_rdata_s;
    logic        is_uart_s, uart_hit_s, mem_we_s;

    // Delayed copy of the reset for logic outside this block
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_rst <= 1'b1;
        end else begin
            wb_rst <= 1'b0;
        end
    end

    // Two synchronizer flops plus a history flop per JTAG pad
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tck_pipe_r <= 3'b000;
            tms_pipe_r <= 3'b000;
            tdi_pipe_r <= 3'b000;
        end else begin
            tck_pipe_r <= {tck_pipe_r[1:0], jtag.tck_pad_i};
            tms_pipe_r <= {tms_pipe_r[1:0], jtag.tms_pad_i};
            tdi_pipe_r <= {tdi_pipe_r[1:0], jtag.tdi_pad_i};
        end
    end

    assign tck_rise_s = tck_pipe_r[1] & ~tck_pipe_r[2];
    assign tck_fall_s = ~tck_pipe_r[1] & tck_pipe_r[2];
    assign tms_s      = tms_pipe_r[2];
    assign tdi_s      = tdi_pipe_r[2];

    // TAP state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tap_state_r <= TAP_TLR;
        end else begin
            tap_state_r <= tap_next_s;
        end
    end

    // IEEE 1149.1 next-state decode, stepping only on a TCK rising edge
    always_comb begin
        tap_next_s = tap_state_r;
        if (tck_rise_s) begin
            case (tap_state_r)
                TAP_TLR:      tap_next_s = tms_s ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      tap_next_s = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   tap_next_s = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   tap_next_s = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: tap_next_s = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: tap_next_s = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: tap_next_s = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: tap_next_s = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   tap_next_s = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   tap_next_s = tms_s ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   tap_next_s = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: tap_next_s = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: tap_next_s = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: tap_next_s = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: tap_next_s = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   tap_next_s = tms_s ? TAP_SEL_DR   : TAP_RTI;
                default:      tap_next_s = TAP_TLR;
            endcase
        end else begin
            tap_next_s = tap_state_r;
        end
    end

    // Instruction register and its shift stage
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ir_r    <= IR_IDCODE;
            ir_sr_r <= 4'h0;
        end else begin
            if (tap_state_r == TAP_TLR) begin
                ir_r <= IR_IDCODE;
            end else if (tck_rise_s && tap_state_r == TAP_UPD_IR) begin
                ir_r <= ir_sr_r;
            end
            if (tck_rise_s && tap_state_r == TAP_CAP_IR) begin
                ir_sr_r <= 4'b0001;
            end else if (tck_rise_s && tap_state_r == TAP_SHIFT_IR) begin
                ir_sr_r <= {tdi_s, ir_sr_r[3:1]};
            end
        end
    end

    // Data registers; unknown instructions fall through to the bypass bit
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            idcode_sr_r <= 32'h0;
            bypass_sr_r <= 1'b0;
            debug_sr_r  <= 65'h0;
        end else if (tck_rise_s && tap_state_r == TAP_CAP_DR) begin
            case (ir_r)
                IR_IDCODE: idcode_sr_r <= IDCODE;
                IR_DEBUG:  debug_sr_r  <= {rdata_r, debug_sr_r[32:1], 1'b0};
                default:   bypass_sr_r <= 1'b0;
            endcase
        end else if (tck_rise_s && tap_state_r == TAP_SHIFT_DR) begin
            case (ir_r)
                IR_IDCODE: idcode_sr_r <= {tdi_s, idcode_sr_r[31:1]};
                IR_DEBUG:  debug_sr_r  <= {tdi_s, debug_sr_r[64:1]};
                default:   bypass_sr_r <= tdi_s;
            endcase
        end
    end

    // LSB of the data register selected by the current instruction
    always_comb begin
        dr_lsb_s = 1'b0;
        case (ir_r)
            IR_IDCODE: dr_lsb_s = idcode_sr_r[0];
            IR_DEBUG:  dr_lsb_s = debug_sr_r[0];
            default:   dr_lsb_s = bypass_sr_r;
        endcase
    end

    // TDO changes on the falling TCK edge so the bench samples it stable on the rise
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tdo_r <= 1'b0;
        end else if (tck_fall_s) begin
            if (tap_state_r == TAP_SHIFT_IR) begin
                tdo_r <= ir_sr_r[0];
            end else if (tap_state_r == TAP_SHIFT_DR) begin
                tdo_r <= dr_lsb_s;
            end else begin
                tdo_r <= 1'b0;
            end
        end
    end

    assign jtag.tdo_pad_o = tdo_r;

    // Latch a debug access at Update-DR; it executes on the next clock
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_req_r   <= 1'b0;
            rd_req_r   <= 1'b0;
            acc_addr_r <= 32'h0;
            acc_data_r <= 32'h0;
        end else if (tck_rise_s && tap_state_r == TAP_UPD_DR && ir_r == IR_DEBUG) begin
            acc_addr_r <= debug_sr_r[32:1];
            acc_data_r <= debug_sr_r[64:33];
            wr_req_r   <= debug_sr_r[0];
            rd_req_r   <= ~debug_sr_r[0];
        end else begin
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
        end
    end

    assign is_uart_s  = (acc_addr_r == UART_BASE);
    assign uart_hit_s = is_uart_s && (UART_SIM != 0);
    assign mem_we_s   = wr_req_r && !uart_hit_s && !wb_rst_i;

    orpsoc_debug_bfm_memory #(.MEM_WORDS(MEM_WORDS), .AW(AW)) wb_bfm_memory0 (
        .clk   (wb_clk_i),
        .we    (mem_we_s),
        .addr  (word_index(acc_addr_r)),
        .wdata (acc_data_r),
        .rdata (ram_rdata_s)
    );

    // Read-back holding register; the UART address always reads as zero
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rdata_r <= 32'h0;
        end else if (rd_req_r) begin
            rdata_r <= is_uart_s ? 32'h0 : ram_rdata_s;
        end
    end

    generate
        if (UART_SIM != 0) begin : g_uart
            // Console character output for simulation
            always_ff @(posedge wb_clk_i) begin
                if (!wb_rst_i && wr_req_r && is_uart_s) begin
                    $write("%c", acc_data_r[7:0]);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_orpsoc_debug_soc.sv
// Bench for orpsoc_debug_soc: table-driven TAP scans, DEBUG RAM accesses checked
// against an array model of memory and read-back data, and reset corner cases.
module tb_orpsoc_debug_soc;
    localparam int          MW        = 256;
    localparam logic [31:0] IDC       = 32'h14951185;
    localparam logic [31:0] UART_ADDR = 32'h90000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    orpsoc_debug_soc_if jtag ();

    orpsoc_debug_soc #(
        .UART_SIM  (1),
        .MEM_WORDS (MW),
        .IDCODE    (IDC),
        .UART_BASE (UART_ADDR)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .jtag     (jtag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   ir;
        int           len;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t         vecs [5];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  mem_model [0:MW-1];
    logic [31:0]  rdata_model;
    logic [31:0]  prev_addr;
    logic [127:0] dout;
    logic [3:0]   cap;
    logic         bit_s;
    logic [31:0]  ra;
    logic [31:0]  rd;
    logic         rw;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % 32'(MW));
    endfunction

    // One TCK period: returns TDO as seen just before this rising edge
    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        @(negedge clk);
        tdo = jtag.tdo_pad_o;
        jtag.tms_pad_i = tms;
        jtag.tdi_pad_i = tdi;
        repeat (3) @(negedge clk);
        jtag.tck_pad_i = 1'b1;
        repeat (8) @(negedge clk);
        jtag.tck_pad_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic shift_bits(input int len, input logic [127:0] din, output logic [127:0] o);
        logic b;
        o = '0;
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, din[i], b);
            o[i] = b;
        end
    endtask

    task automatic load_ir(input logic [3:0] code, output logic [3:0] captured);
        logic b;
        logic [127:0] o;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        shift_bits(4, 128'(code), o);
        captured = o[3:0];
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int len, input logic [127:0] din, output logic [127:0] o);
        logic b;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        shift_bits(len, din, o);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    // Each DEBUG scan also reports what the previous access left behind
    task automatic debug_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input string name);
        logic [127:0] o;
        scan_dr(65, 128'({data, addr, we}), o);
        check({name, "_rdata"}, 64'(o[64:33]), 64'(rdata_model));
        check({name, "_addr"}, 64'(o[32:1]), 64'(prev_addr));
        check({name, "_flag"}, 64'(o[0]), 64'd0);
        prev_addr = addr;
        if (we) begin
            if (addr != UART_ADDR) mem_model[idx_of(addr)] = data;
        end else begin
            rdata_model = (addr == UART_ADDR) ? 32'h0 : mem_model[idx_of(addr)];
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < MW; i++) begin
            if (dut.wb_bfm_memory0.ram0.mem[i] !== mem_model[i]) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    initial begin
        // Bypass vectors shift 1,0,1,1 (LSB first) and expect it one TCK late behind the captured 0
        vecs[0] = '{"idcode32", 4'h2, 32, 128'h0, 128'(IDC)};
        vecs[1] = '{"bypass_f", 4'hF, 4, 128'hD, 128'hA};
        vecs[2] = '{"bypass_unk", 4'h5, 4, 128'hD, 128'hA};
        vecs[3] = '{"idcode36", 4'h2, 36, 128'hB, 128'({4'hB, IDC})};
        vecs[4] = '{"bypass_1", 4'h0, 3, 128'h7, 128'h6};

        jtag.tms_pad_i = 1'b0;
        jtag.tck_pad_i = 1'b0;
        jtag.tdi_pad_i = 1'b0;
        rdata_model = 32'h0;
        prev_addr   = 32'h0;

        @(negedge clk);
        for (int i = 0; i < MW; i++) begin
            mem_model[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        end
        mem_model[5] = 32'hDEADBEEF;
        for (int i = 0; i < MW; i++) begin
            dut.wb_bfm_memory0.ram0.mem[i] = mem_model[i];
        end

        repeat (9) @(negedge clk);
        check("wb_rst_held", 64'(dut.wb_rst), 64'd1);
        rst = 1'b0;
        check("wb_rst_delay", 64'(dut.wb_rst), 64'd1);
        @(posedge clk);
        #1;
        check("wb_rst_release", 64'(dut.wb_rst), 64'd0);
        check("tdo_reset", 64'(jtag.tdo_pad_o), 64'd0);

        // IR must come out of reset as IDCODE
        tick(1'b0, 1'b0, bit_s);
        scan_dr(32, 128'h0, dout);
        check("idcode_after_reset", 64'(dout[31:0]), 64'(IDC));
        check("tdo_idle", 64'(jtag.tdo_pad_o), 64'd0);

        for (int v = 0; v < 5; v++) begin
            load_ir(vecs[v].ir, cap);
            check({vecs[v].name, "_ircap"}, 64'(cap), 64'h1);
            scan_dr(vecs[v].len, vecs[v].din, dout);
            check(vecs[v].name, dout[63:0], vecs[v].dexp[63:0]);
        end

        load_ir(4'h8, cap);
        debug_op(1'b0, 32'h14, 32'h0, "read_m5");
        debug_op(1'b1, 32'h20, 32'h12345678, "write_m8");
        check("read_m5_data", 64'(rdata_model), 64'hDEADBEEF);
        check_mem("mem_after_write");
        check("mem8", 64'(dut.wb_bfm_memory0.ram0.mem[8]), 64'h12345678);

        debug_op(1'b1, UART_ADDR, 32'h41, "uart_write");
        $display("");
        check_mem("mem_after_uart");
        debug_op(1'b0, UART_ADDR, 32'h0, "uart_read");
        debug_op(1'b0, 32'h20 | 32'(MW * 4), 32'h0, "wrap_read");

        for (int k = 0; k < 14; k++) begin
            ra = ($urandom & 32'h7FFF_FC00) | (32'($urandom_range(0, 7)) << 2);
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            debug_op(rw, ra, rd, "rand");
        end
        debug_op(1'b0, 32'h0, 32'h0, "rand_tail");
        check_mem("mem_after_random");

        // Reset in the middle of a DEBUG write scan must abort it
        tick(1'b1, 1'b0, bit_s);
        tick(1'b0, 1'b0, bit_s);
        tick(1'b0, 1'b0, bit_s);
        shift_bits(20, 128'({32'hCAFEF00D, 32'h24, 1'b1}), dout);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        rdata_model = 32'h0;
        prev_addr   = 32'h0;
        repeat (2) @(negedge clk);
        check("tdo_mid_reset", 64'(jtag.tdo_pad_o), 64'd0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, bit_s);
        tick(1'b0, 1'b0, bit_s);
        check_mem("mem_after_abort");
        scan_dr(32, 128'h0, dout);
        check("idcode_after_abort", 64'(dout[31:0]), 64'(IDC));
        load_ir(4'h8, cap);
        debug_op(1'b0, 32'h24, 32'h0, "post_reset");
        debug_op(1'b0, 32'h24, 32'h0, "post_reset_rd");
        check_mem("mem_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
